bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of a 2K x 9 dual-port block RAM between two requesters (PicoBlaze-side data port and a DMA/host loader).
- Per-requester request/grant handshake; one access per cycle; fixed 1-cycle read latency.
- Round-robin fairness, plus a bounded lock for short bursts.
- Sits between the requesters and the RAM's port-A pins; port B is untouched.

Parameters:
ADDR_W, 11, RAM address width (2048 words)
DATA_W, 8, data byte width
PAR_W, 1, parity width
MAX_LOCK, 4, max consecutive locked grants while the other requester waits (1..15)

Ports:
CLK  in  1  clock; RAM port clock is driven from the same net
RST_N  in  1  asynchronous active-low reset
REQ0/REQ1  in  1  access request, held until granted
WE0/WE1  in  1  1 = write, 0 = read; valid with REQn
LOCK0/LOCK1  in  1  requester asks to keep priority on its next access
ADDR0/ADDR1  in  ADDR_W  access address
DI0/DI1  in  DATA_W  write data
DIP0/DIP1  in  PAR_W  write parity
GNT0/GNT1  out  1  grant; an access completes at a rising edge where REQn & GNTn
RVALID0/RVALID1  out  1  read data valid, registered
DO0/DO1  out  DATA_W  read data, meaningful only while RVALIDn
DOP0/DOP1  out  PAR_W  read parity
RAM_EN  out  1  RAM port enable
RAM_WE  out  1  RAM port write enable
RAM_SSR  out  1  RAM set/reset, constant 0
RAM_ADDR  out  ADDR_W  RAM address
RAM_DI  out  DATA_W  RAM write data
RAM_DIP  out  PAR_W  RAM write parity
RAM_DO  in  DATA_W  RAM read data
RAM_DOP  in  PAR_W  RAM read parity

Behaviour:
- Reset (RST_N low, asynchronous):
  - GNT0/1 = 0; RVALID0/1 = 0; RAM_EN = 0; RAM_WE = 0; RAM_SSR = 0.
  - Priority pointer LAST = 1, so requester 0 wins first; lock counter LCNT = 0; owner register OWN = none.
- Grant logic is combinational from REQ, LAST and lock state; at most one GNT high per cycle.
- Priority when no lock is active:
  - Only REQn high: grant n.
  - Both high: grant the requester other than LAST.
- Lock state:
  - Set when an access by n completes with LOCKn = 1 and LCNT < MAX_LOCK; then OWN = n.
  - While OWN = n, n wins every contest.
  - LCNT increments on each completed access by n while the other REQ is high.
  - Lock releases (OWN = none, LCNT = 0) when n completes an access with LOCKn = 0, or when LCNT reaches MAX_LOCK; the next contest then goes to the other requester.
  - If REQn drops while OWN = n, the lock is released immediately and the other requester may be granted in that same cycle.
- LAST updates to n on every completed access by n.
- RAM drive (combinational mux of the granted requester):
  - RAM_EN = |GNT; RAM_WE = granted WEn & RAM_EN; RAM_ADDR/RAM_DI/RAM_DIP from the granted requester.
  - When idle, RAM_ADDR/RAM_DI/RAM_DIP are 0.
- Read return:
  - A read completed at edge t raises RVALIDn for exactly the cycle following t.
  - DOn/DOPn = RAM_DO/RAM_DOP while RVALIDn; DOn/DOPn = 0 otherwise.
  - Writes never raise RVALID; WRITE_FIRST echo data is ignored.
- Back-to-back:
  - A requester can complete an access every cycle; RVALID stays high continuously for consecutive reads.
  - A read by 0 followed immediately by a read by 1 gives RVALID0 then RVALID1 on successive cycles.
- Same-cycle events: REQ and LOCK are sampled at the same edge; lock release and a new grant take effect in the same cycle.
- Reset mid-operation: any pending RVALID is dropped and never issued; the lock is cleared.

Test Plan:
- Reset values: hold RST_N low with REQ0 = REQ1 = 1 -> all GNT/RVALID/RAM_EN/RAM_WE = 0. Release reset -> GNT0 = 1 in the first cycle.
- Write/readback: req0 writes 0xA5/parity 1 to 0x123, then reads 0x123 -> RAM_WE = 1 for one cycle only; RVALID0 = 1 exactly one cycle after the read grant; DO0 = 0xA5, DOP0 = 1.
- Round-robin: REQ0 and REQ1 both held high, reads, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1; each RVALID follows its grant by 1 cycle.
- Lock bound: MAX_LOCK = 4, REQ1 held, req0 reads with LOCK0 = 1 continuously -> req0 gets 4 consecutive grants, then GNT1 = 1 on the 5th cycle.
- Lock drop: req0 locked, deasserts REQ0 while REQ1 is high -> GNT1 in the same cycle; OWN cleared.
- Reset mid-read: RST_N low in the cycle after a req1 read grant -> RVALID1 never asserts; after reset, LAST = 1 so req0 wins the first contest.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for port A of a 2K x 9 block RAM.
// Round-robin with a bounded lock; reads return one cycle after the grant edge.
module bram_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int PAR_W    = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic              LOCK0,
  input  logic              LOCK1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DI0,
  input  logic [DATA_W-1:0] DI1,
  input  logic [PAR_W-1:0]  DIP0,
  input  logic [PAR_W-1:0]  DIP1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] DO0,
  output logic [DATA_W-1:0] DO1,
  output logic [PAR_W-1:0]  DOP0,
  output logic [PAR_W-1:0]  DOP1,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_SSR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  output logic [PAR_W-1:0]  RAM_DIP,
  input  logic [DATA_W-1:0] RAM_DO,
  input  logic [PAR_W-1:0]  RAM_DOP
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_0 = 2'd1, OWN_1 = 2'd2} own_t;

  own_t       own_r, own_nxt_s;
  logic [3:0] lcnt_r, lcnt_nxt_s;
  logic       last_r, last_nxt_s;
  logic       rvalid0_r, rvalid1_r;
  logic       gnt0_s, gnt1_s;
  logic [4:0] cnt_s;

  // Grants are gated by reset so nothing is granted while RST_N is low.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!RST_N) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (own_r == OWN_0 && REQ0) begin
      gnt0_s = 1'b1;
    end else if (own_r == OWN_1 && REQ1) begin
      gnt1_s = 1'b1;
    end else if (REQ0 && REQ1) begin
      if (last_r) gnt0_s = 1'b1;
      else        gnt1_s = 1'b1;
    end else begin
      gnt0_s = REQ0;
      gnt1_s = REQ1;
    end
  end

  // Count continues only for the current owner; a fresh lock starts from zero.
  always_comb begin
    own_nxt_s  = own_r;
    lcnt_nxt_s = lcnt_r;
    last_nxt_s = last_r;
    cnt_s      = 5'd0;
    if (gnt0_s) begin
      last_nxt_s = 1'b0;
      cnt_s = ((own_r == OWN_0) ? {1'b0, lcnt_r} : 5'd0) + {4'd0, REQ1};
      if (LOCK0 && cnt_s < 5'(MAX_LOCK)) begin
        own_nxt_s  = OWN_0;
        lcnt_nxt_s = cnt_s[3:0];
      end else begin
        own_nxt_s  = OWN_NONE;
        lcnt_nxt_s = 4'd0;
      end
    end else if (gnt1_s) begin
      last_nxt_s = 1'b1;
      cnt_s = ((own_r == OWN_1) ? {1'b0, lcnt_r} : 5'd0) + {4'd0, REQ0};
      if (LOCK1 && cnt_s < 5'(MAX_LOCK)) begin
        own_nxt_s  = OWN_1;
        lcnt_nxt_s = cnt_s[3:0];
      end else begin
        own_nxt_s  = OWN_NONE;
        lcnt_nxt_s = 4'd0;
      end
    end else begin
      own_nxt_s  = OWN_NONE;
      lcnt_nxt_s = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      own_r     <= OWN_NONE;
      lcnt_r    <= 4'd0;
      last_r    <= 1'b1;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      own_r     <= own_nxt_s;
      lcnt_r    <= lcnt_nxt_s;
      last_r    <= last_nxt_s;
      rvalid0_r <= gnt0_s & ~WE0;
      rvalid1_r <= gnt1_s & ~WE1;
    end
  end

  always_comb begin
    RAM_ADDR = {ADDR_W{1'b0}};
    RAM_DI   = {DATA_W{1'b0}};
    RAM_DIP  = {PAR_W{1'b0}};
    if (gnt0_s) begin
      RAM_ADDR = ADDR0;
      RAM_DI   = DI0;
      RAM_DIP  = DIP0;
    end else if (gnt1_s) begin
      RAM_ADDR = ADDR1;
      RAM_DI   = DI1;
      RAM_DIP  = DIP1;
    end else begin
      RAM_ADDR = {ADDR_W{1'b0}};
      RAM_DI   = {DATA_W{1'b0}};
      RAM_DIP  = {PAR_W{1'b0}};
    end
  end

  assign GNT0    = gnt0_s;
  assign GNT1    = gnt1_s;
  assign RAM_EN  = gnt0_s | gnt1_s;
  assign RAM_WE  = (gnt0_s & WE0) | (gnt1_s & WE1);
  assign RAM_SSR = 1'b0;
  assign RVALID0 = rvalid0_r;
  assign RVALID1 = rvalid1_r;
  assign DO0     = rvalid0_r ? RAM_DO  : {DATA_W{1'b0}};
  assign DOP0    = rvalid0_r ? RAM_DOP : {PAR_W{1'b0}};
  assign DO1     = rvalid1_r ? RAM_DO  : {DATA_W{1'b0}};
  assign DOP1    = rvalid1_r ? RAM_DOP : {PAR_W{1'b0}};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural write-first RAM on port A.
module tb_bram_port_arbiter;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
  logic [10:0] ADDR0, ADDR1;
  logic [7:0]  DI0, DI1;
  logic [0:0]  DIP0, DIP1;
  logic        GNT0, GNT1, RVALID0, RVALID1;
  logic [7:0]  DO0, DO1;
  logic [0:0]  DOP0, DOP1;
  logic        RAM_EN, RAM_WE, RAM_SSR;
  logic [10:0] RAM_ADDR;
  logic [7:0]  RAM_DI;
  logic [0:0]  RAM_DIP;
  logic [7:0]  RAM_DO;
  logic [0:0]  RAM_DOP;
  logic [8:0]  mem [0:2047];
  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.ADDR_W(11), .DATA_W(8), .PAR_W(1), .MAX_LOCK(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DI0(DI0), .DI1(DI1), .DIP0(DIP0), .DIP1(DIP1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .DO0(DO0), .DO1(DO1), .DOP0(DOP0), .DOP1(DOP1),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_DIP(RAM_DIP), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) begin
        mem[RAM_ADDR] <= {RAM_DIP, RAM_DI};
        {RAM_DOP, RAM_DO} <= {RAM_DIP, RAM_DI};
      end else begin
        {RAM_DOP, RAM_DO} <= mem[RAM_ADDR];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_g(input logic e0, input logic e1, input string tag);
    @(negedge CLK);
    chk({tag, "_gnt0"}, {31'd0, GNT0}, {31'd0, e0});
    chk({tag, "_gnt1"}, {31'd0, GNT1}, {31'd0, e1});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0;
    LOCK0 = 1'b0; LOCK1 = 1'b0; ADDR0 = 11'd0; ADDR1 = 11'd0;
    DI0 = 8'd0; DI1 = 8'd0; DIP0 = 1'b0; DIP1 = 1'b0;

    // Reset values with both requesting
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt0", {31'd0, GNT0}, 32'd0);
    chk("rst_gnt1", {31'd0, GNT1}, 32'd0);
    chk("rst_rvalid0", {31'd0, RVALID0}, 32'd0);
    chk("rst_rvalid1", {31'd0, RVALID1}, 32'd0);
    chk("rst_ram_en", {31'd0, RAM_EN}, 32'd0);
    chk("rst_ram_we", {31'd0, RAM_WE}, 32'd0);
    chk("rst_ram_ssr", {31'd0, RAM_SSR}, 32'd0);
    RST_N = 1'b1;
    #1;
    chk("first_gnt0", {31'd0, GNT0}, 32'd1);
    chk("first_gnt1", {31'd0, GNT1}, 32'd0);
    chk("first_ram_en", {31'd0, RAM_EN}, 32'd1);
    @(posedge CLK); #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    chk("first_rvalid0", {31'd0, RVALID0}, 32'd1);
    chk("idle_ram_en", {31'd0, RAM_EN}, 32'd0);
    chk("idle_ram_addr", {21'd0, RAM_ADDR}, 32'd0);

    // Write 0xA5 / parity 1 to 0x123, then read it back
    @(posedge CLK); #1;
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 11'h123; DI0 = 8'hA5; DIP0 = 1'b1;
    @(negedge CLK);
    chk("wr_gnt0", {31'd0, GNT0}, 32'd1);
    chk("wr_ram_we", {31'd0, RAM_WE}, 32'd1);
    chk("wr_ram_addr", {21'd0, RAM_ADDR}, 32'h123);
    chk("wr_ram_di", {24'd0, RAM_DI}, 32'hA5);
    chk("wr_ram_dip", {31'd0, RAM_DIP}, 32'd1);
    chk("wr_rvalid0", {31'd0, RVALID0}, 32'd0);
    @(posedge CLK); #1;
    WE0 = 1'b0;
    @(negedge CLK);
    chk("rd_gnt0", {31'd0, GNT0}, 32'd1);
    chk("rd_ram_we", {31'd0, RAM_WE}, 32'd0);
    chk("rd_no_wr_rvalid", {31'd0, RVALID0}, 32'd0);
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("rd_rvalid0", {31'd0, RVALID0}, 32'd1);
    chk("rd_do0", {24'd0, DO0}, 32'hA5);
    chk("rd_dop0", {31'd0, DOP0}, 32'd1);
    chk("rd_rvalid1", {31'd0, RVALID1}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rd_rvalid0_off", {31'd0, RVALID0}, 32'd0);
    chk("rd_do0_off", {24'd0, DO0}, 32'd0);

    // Round-robin from a fresh reset (LAST = 1)
    @(posedge CLK); #1;
    RST_N = 1'b0; #2; RST_N = 1'b1;
    ADDR1 = 11'h050; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("rr%0d_gnt0", i), {31'd0, GNT0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_gnt1", i), {31'd0, GNT1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_rvalid0", i), {31'd0, RVALID0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_rvalid1", i), {31'd0, RVALID1}, (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 1) chk($sformatf("rr%0d_do0", i), {24'd0, DO0}, 32'hA5);
      @(posedge CLK); #1;
    end

    // Lock bound: four locked grants to 0, then 1
    LOCK0 = 1'b1;
    cyc_g(1'b1, 1'b0, "lk0");
    cyc_g(1'b1, 1'b0, "lk1");
    cyc_g(1'b1, 1'b0, "lk2");
    cyc_g(1'b1, 1'b0, "lk3");
    cyc_g(1'b0, 1'b1, "lk4");
    cyc_g(1'b1, 1'b0, "lk5");
    // Owner drops its request: other side granted at once
    REQ0 = 1'b0;
    cyc_g(1'b0, 1'b1, "drop");
    // A fresh lock must count from zero again
    REQ0 = 1'b1;
    cyc_g(1'b1, 1'b0, "rl0");
    cyc_g(1'b1, 1'b0, "rl1");
    cyc_g(1'b1, 1'b0, "rl2");
    cyc_g(1'b1, 1'b0, "rl3");
    cyc_g(1'b0, 1'b1, "rl4");

    // Reset while a req1 read is granted but not yet returned
    LOCK0 = 1'b0; REQ1 = 1'b0;
    cyc_g(1'b1, 1'b0, "pre");
    REQ0 = 1'b0; REQ1 = 1'b1;
    @(negedge CLK);
    chk("mid_gnt1", {31'd0, GNT1}, 32'd1);
    RST_N = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("mid%0d_rvalid1", k), {31'd0, RVALID1}, 32'd0);
      chk($sformatf("mid%0d_gnt1", k), {31'd0, GNT1}, 32'd0);
    end
    REQ0 = 1'b1; REQ1 = 1'b1; RST_N = 1'b1;
    #1;
    chk("post_gnt0", {31'd0, GNT0}, 32'd1);
    chk("post_gnt1", {31'd0, GNT1}, 32'd0);
    @(negedge CLK);
    chk("post_rvalid1", {31'd0, RVALID1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
